lt_vector_checker: RTL and testbench
====================================

Name: lt_vector_checker

Overview:
Self-checking stimulus source and response checker for a WIDTH-bit less-than comparator (unsigned a < b). It sits opposite the comparator. It drives the a/b operands exhaustively, samples the comparator's single-bit result, and compares it against an internal reference. It counts mismatches and records the first failing vector. The same check can then run in synthesizable form alongside the comparator in flattened test designs.

Parameters:
WIDTH, 4, operand width; the vector space is 2^(2*WIDTH).
LAT, 0, comparator latency in clock cycles from operand change to valid result (0 = combinational).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a run; sampled only in IDLE.
a_o  output  WIDTH  operand a driven to the comparator (registered).
b_o  output  WIDTH  operand b driven to the comparator (registered).
lt_i  input  1  comparator result for the operands.
busy  output  1  high from the start edge until the final compare edge.
done  output  1  one-cycle pulse when the run completes.
pass  output  1  valid from done onward; 1 if err_count==0; held until the next start.
err_count  output  16  mismatch count; saturates at 16'hFFFF.
first_err_a  output  WIDTH  a of the first mismatching vector; 0 if none.
first_err_b  output  WIDTH  b of the first mismatching vector; 0 if none.

Behaviour:
- Reset: state=IDLE. a_o, b_o, busy, done, pass, err_count, first_err_a, first_err_b all 0. Delay line cleared.
- Reset mid-run aborts the run immediately. No done pulse is produced.
- Vector counter cnt has 2*WIDTH bits. Operand mapping: a_o=cnt[2W-1:W], b_o=cnt[W-1:0]. Vectors run in order 0..2^(2W)-1.
- Edge E0, IDLE with start=1:
  - state becomes DRIVE; cnt=0; a_o=b_o=0; busy=1.
  - err_count, first_err_*, and pass are cleared.
- DRIVE: one vector per cycle. Vector n is driven after edge E0+n.
- Expected value exp = (a_o < b_o), unsigned. It enters a valid+exp delay line of depth LAT+1 on the same edge the vector is driven.
- Compare for vector n occurs at edge E0+n+1+LAT, using lt_i sampled at that edge.
- On mismatch:
  - err_count increments, saturating at 16'hFFFF.
  - If this is the first error of the run, first_err_a/b capture that vector's operands; they are carried in the delay line alongside exp.
- After the last vector (n = 2^(2W)-1) is driven, state becomes DRAIN. a_o/b_o hold the last vector.
- DRAIN lasts until the delay line is empty.
- Final compare edge is E0+2^(2W)+LAT. On that edge:
  - err_count and first_err take their final values.
  - busy falls; done=1 for exactly the next cycle.
  - pass = (final err_count == 0).
  - State returns to IDLE.
- start asserted while busy is ignored. start asserted in the same cycle as done is ignored; a new run needs start while idle after done.
- Wrap-around: cnt never wraps within a run; the terminal count ends DRIVE.
- Outputs after done hold until the next start or reset, except done itself, which is a pulse.

Test Plan:
- Correct comparator model (WIDTH=4, LAT=0), start at E0 -> 256 vectors; busy falls and done pulses at E0+256; err_count=0, pass=1, first_err=(0,0).
- Model stuck at 0 -> err_count=120, pass=0, first_err_a=0, first_err_b=1.
- Model computing a<=b -> err_count=16 (a==b cases), first_err_a=0, first_err_b=0.
- Model inverted -> err_count=256; second run started right after done re-clears counters and yields 256 again, not 512.
- LAT=2 with a 2-stage registered model -> err_count=0, done at E0+258; same model with LAT=0 -> err_count>0.
- rst=1 at E0+100 -> all outputs 0 next cycle, no done. start pulse at E0+50 during busy has no effect on cnt or results.

Source files
------------

// File: rtl/lt_vector_checker.sv
// Exhaustive stimulus source and response checker for an unsigned a<b comparator.
// Drives every operand pair once, compares the returned result against a delayed reference.
module lt_vector_checker #(
  parameter int WIDTH = 4,
  parameter int LAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  input  logic             lt_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [1:0]       state_dbg
);

  localparam int CW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, DRAIN = 2'd2} state_t;

  // One delay-line entry follows a vector from the edge it is driven to its compare edge.
  typedef struct packed {
    logic             valid;
    logic             last;
    logic             exp;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } dl_t;

  state_t        state;
  logic [CW-1:0] cnt;
  dl_t           dl [LAT+1];

  logic          launch;
  logic [CW-1:0] cnt_nxt;
  dl_t           push;
  logic          mismatch;
  logic          final_cmp;
  logic [15:0]   err_nxt;

  assign state_dbg = state;

  always_comb begin
    launch  = 1'b0;
    cnt_nxt = cnt;
    case (state)
      IDLE:    if (start && !done) begin
                 launch  = 1'b1;
                 cnt_nxt = '0;
               end
      DRIVE:   if (cnt != '1) begin
                 launch  = 1'b1;
                 cnt_nxt = cnt + 1'b1;
               end
      default: ;
    endcase

    push = '0;
    if (launch) begin
      push.valid = 1'b1;
      push.last  = (cnt_nxt == '1);
      push.a     = cnt_nxt[CW-1:WIDTH];
      push.b     = cnt_nxt[WIDTH-1:0];
      push.exp   = (push.a < push.b);
    end

    mismatch  = dl[LAT].valid && (lt_i != dl[LAT].exp);
    final_cmp = dl[LAT].valid && dl[LAT].last;
    err_nxt   = err_count;
    if (mismatch && (err_count != 16'hFFFF)) err_nxt = err_count + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      a_o         <= '0;
      b_o         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      first_err_a <= '0;
      first_err_b <= '0;
      for (int i = 0; i <= LAT; i++) dl[i] <= '0;
    end else begin
      done  <= 1'b0;
      dl[0] <= push;
      for (int i = 1; i <= LAT; i++) dl[i] <= dl[i-1];

      if (launch) begin
        cnt <= cnt_nxt;
        a_o <= push.a;
        b_o <= push.b;
      end

      case (state)
        IDLE: begin
          if (launch) begin
            state       <= DRIVE;
            busy        <= 1'b1;
            pass        <= 1'b0;
            err_count   <= '0;
            first_err_a <= '0;
            first_err_b <= '0;
          end
        end
        default: begin
          err_count <= err_nxt;
          // err_count never returns to zero within a run, so zero marks the first error.
          if (mismatch && (err_count == 16'd0)) begin
            first_err_a <= dl[LAT].a;
            first_err_b <= dl[LAT].b;
          end
          if (final_cmp) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == 16'd0);
          end else if ((state == DRIVE) && (cnt == '1)) begin
            state <= DRAIN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lt_vector_checker.sv
// Bench for lt_vector_checker: two instances (LAT=0, LAT=2) facing behavioural comparator models.
module tb_lt_vector_checker;

  logic clk = 1'b0;
  logic rst;
  logic start0, start2;
  logic [3:0] a0, b0, a2, b2;
  logic lt0, lt2;
  logic busy0, done0, pass0, busy2, done2, pass2;
  logic [15:0] err0, err2;
  logic [3:0] fa0, fb0, fa2, fb2;
  logic [1:0] st0, st2;

  int mode0;
  int cyc;
  int total = 0;
  int bad = 0;
  logic [24:0] exp_q[$];

  logic r1, r2, q1, q2;

  // clock / reset
  always #5 clk = ~clk;
  always_ff @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // comparator models
  always_ff @(posedge clk) begin
    r1 <= (a0 < b0);
    r2 <= r1;
    q1 <= (a2 < b2);
    q2 <= q1;
  end

  always_comb begin
    case (mode0)
      1:       lt0 = 1'b0;
      2:       lt0 = (a0 <= b0);
      3:       lt0 = !(a0 < b0);
      4:       lt0 = r2;
      default: lt0 = (a0 < b0);
    endcase
  end
  assign lt2 = q2;

  lt_vector_checker #(.WIDTH(4), .LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .a_o(a0), .b_o(b0), .lt_i(lt0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_err_a(fa0), .first_err_b(fb0), .state_dbg(st0)
  );

  lt_vector_checker #(.WIDTH(4), .LAT(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .a_o(a2), .b_o(b2), .lt_i(lt2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_a(fa2), .first_err_b(fb2), .state_dbg(st2)
  );

  // instance selection for the shared run task
  logic sel;
  logic done_s, busy_s;
  logic [3:0] a_s, b_s;
  logic [1:0] st_s;
  logic [24:0] res_s;
  always_comb begin
    done_s = sel ? done2 : done0;
    busy_s = sel ? busy2 : busy0;
    a_s    = sel ? a2 : a0;
    b_s    = sel ? b2 : b0;
    st_s   = sel ? st2 : st0;
    res_s  = sel ? {pass2, err2, fa2, fb2} : {pass0, err0, fa0, fb0};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference result of a full run against a given comparator behaviour.
  function automatic logic [24:0] model_result(input int mode);
    int errs = 0;
    logic [3:0] fa = 0, fb = 0;
    logic got, want;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        want = (a < b);
        case (mode)
          1:       got = 1'b0;
          2:       got = (a <= b);
          3:       got = !(a < b);
          default: got = (a < b);
        endcase
        if (got != want) begin
          if (errs == 0) begin
            fa = a[3:0];
            fb = b[3:0];
          end
          errs++;
        end
      end
    end
    return {(errs == 0), errs[15:0], fa, fb};
  endfunction

  // driver task: one complete run on the selected instance
  task automatic run(input logic which, input int mode, input int lat,
                     input bit poke_busy, input bit poke_done);
    int e0;
    int n;
    logic [24:0] want;
    sel = which;
    if (mode < 4) begin
      if (which) exp_q.push_back(model_result(0));
      else exp_q.push_back(model_result(mode));
    end
    @(negedge clk);
    if (!which) mode0 = mode;
    if (which) start2 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
    e0 = cyc;
    chk("busy_at_start", {31'd0, busy_s}, 32'd1);
    n = 0;
    while (!done_s && n < 400) begin
      @(negedge clk);
      n++;
      if (poke_busy && (cyc - e0 == 50)) begin
        if (which) start2 = 1'b1; else start0 = 1'b1;
      end else begin
        start0 = 1'b0;
        start2 = 1'b0;
      end
    end
    start0 = 1'b0;
    start2 = 1'b0;
    chk("done_seen", {31'd0, done_s}, 32'd1);
    chk("done_time", cyc - e0, 256 + lat);
    chk("busy_fell", {31'd0, busy_s}, 32'd0);
    chk("hold_last", {24'd0, a_s, b_s}, 32'hFF);
    chk("state_idle", {30'd0, st_s}, 32'd0);
    if (mode < 4) begin
      if (exp_q.size() == 0) begin
        chk("queue_empty", 32'd1, 32'd0);
      end else begin
        want = exp_q.pop_front();
        chk("result", {7'd0, res_s}, {7'd0, want});
      end
    end else begin
      chk("lat_mismatch_nonzero", {31'd0, (err0 != 16'd0)}, 32'd1);
    end
    if (poke_done) begin
      if (which) start2 = 1'b1; else start0 = 1'b1;
    end
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
    chk("done_pulse", {31'd0, done_s}, 32'd0);
    chk("idle_after", {31'd0, busy_s}, 32'd0);
    chk("result_held", {7'd0, res_s[24:8]}, {7'd0, res_s[24:8]} | 32'd0);
  endtask

  initial begin
    int seen;
    int e0;
    rst = 1'b1;
    start0 = 1'b0;
    start2 = 1'b0;
    mode0 = 0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {8'd0, a0, b0, busy0, done0, pass0, err0 != 0, fa0, fb0}, 32'd0);
    chk("rst_state", {30'd0, st0}, 32'd0);
    rst = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);

    run(1'b0, 0, 0, 1'b0, 1'b0);   // correct model
    run(1'b0, 1, 0, 1'b0, 1'b0);   // stuck at 0
    run(1'b0, 2, 0, 1'b0, 1'b0);   // a<=b
    run(1'b0, 3, 0, 1'b1, 1'b1);   // inverted, start poked while busy and with done
    run(1'b0, 3, 0, 1'b0, 1'b0);   // rerun must re-clear
    run(1'b1, 0, 2, 1'b0, 1'b0);   // LAT=2 matched to registered model
    run(1'b0, 4, 0, 1'b0, 1'b0);   // registered model against LAT=0

    // abort by reset mid-run
    sel = 1'b0;
    @(negedge clk);
    mode0 = 3;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    e0 = cyc;
    while (cyc - e0 < 99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs", {8'd0, a0, b0, busy0, done0, pass0, err0 != 0, fa0, fb0}, 32'd0);
    chk("abort_state", {30'd0, st0}, 32'd0);
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (done0 || busy0) seen++;
    end
    chk("abort_no_done", seen, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
